// File: rtl/rede_pkg.sv
// Shared definitions for the network instruction stream: word tags, descriptor
// layout, validation limits and the transmitter FSM states.
package rede_pkg;

  // Word tags carried in instrucao[9:8].
  localparam logic [1:0] TAG_HDR = 2'b00;
  localparam logic [1:0] TAG_LO  = 2'b01;
  localparam logic [1:0] TAG_HI  = 2'b10;
  localparam logic [1:0] TAG_END = 2'b11;

  // Layer descriptor layout (13 bits per layer, 4 slots on the config bus).
  localparam int unsigned DESC_W    = 13;
  localparam int unsigned NUM_SLOTS = 4;
  localparam int unsigned ENTR_LSB  = 0;
  localparam int unsigned ENTR_MSB  = 4;
  localparam int unsigned FA_LSB    = 5;
  localparam int unsigned FA_MSB    = 6;
  localparam int unsigned BIAS_BIT  = 7;
  localparam int unsigned NEURO_LSB = 8;
  localparam int unsigned NEURO_MSB = 12;

  // Largest field values the network accepts.
  localparam int unsigned MAX_NEURO = 19;
  localparam int unsigned MAX_ENTR  = 19;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StSend,
    StGap,
    StDone,
    StErr
  } estado_e;

  // True when a descriptor carries an out-of-range input or neuron count.
  function automatic logic desc_invalido(input logic [DESC_W-1:0] d);
    return (d[ENTR_MSB:ENTR_LSB] > 5'(MAX_ENTR)) || (d[NEURO_MSB:NEURO_LSB] > 5'(MAX_NEURO));
  endfunction

endpackage

// File: rtl/emissor_instrucao_montador_palavra.sv
// Combinational word builder: formats one 10-bit instruction word from its tag,
// the layer index, that layer's descriptor, the layer count and the checksum.
module montador_palavra
  import rede_pkg::*;
(
  input  logic [1:0]        tag,
  input  logic [1:0]        camada,
  input  logic [DESC_W-1:0] desc,
  input  logic [2:0]        qtd,
  input  logic [7:0]        chk,
  output logic [9:0]        palavra
);

  // Select the payload layout for the requested tag.
  always_comb begin
    palavra = '0;
    case (tag)
      TAG_HDR: palavra = {TAG_HDR, 5'b0, qtd};
      TAG_LO:  palavra = {TAG_LO, desc[7:0]};
      TAG_HI:  palavra = {TAG_HI, camada, 1'b0, desc[NEURO_MSB:NEURO_LSB]};
      default: palavra = {TAG_END, chk};
    endcase
  end

endmodule

// File: rtl/emissor_instrucao.sv
// Instruction stream transmitter: latches a layer configuration on start,
// validates it, then emits HEADER, LOW/HIGH per layer and a checksummed END,
// each word marked by a one-cycle flag_inst strobe.
module emissor_instrucao
  import rede_pkg::*;
#(
  parameter int unsigned GAP         = 2,
  parameter int unsigned MAX_CAMADAS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          hold,
  input  logic [2:0]                    cfg_qtd_camadas,
  input  logic [NUM_SLOTS*DESC_W-1:0]   cfg_camadas,
  output logic [9:0]                    instrucao,
  output logic                          flag_inst,
  output logic                          busy,
  output logic                          done,
  output logic                          erro
);

  // Last gap count value before returning to SEND; unused when GAP is 0.
  localparam logic [3:0] GAP_FIM = 4'((GAP == 0) ? 0 : GAP - 1);

  estado_e                             estado_q;
  logic [2:0]                          qtd_q;
  logic [NUM_SLOTS-1:0][DESC_W-1:0]    desc_q;
  logic [3:0]                          idx_q;
  logic [3:0]                          gap_q;
  logic [7:0]                          chk_q;

  logic [3:0]        idx_m1;
  logic [1:0]        camada;
  logic [1:0]        tag_atual;
  logic [9:0]        palavra;
  logic              cfg_err;

  // Word index 0 is HEADER, 2k+1 is LOW(k), 2k+2 is HIGH(k), 2N+1 is END.
  always_comb begin
    idx_m1 = idx_q - 4'd1;
    camada = idx_m1[2:1];
    if (idx_q == 4'd0) begin
      tag_atual = TAG_HDR;
    end else if (idx_q == {qtd_q, 1'b1}) begin
      tag_atual = TAG_END;
    end else if (idx_q[0]) begin
      tag_atual = TAG_LO;
    end else begin
      tag_atual = TAG_HI;
    end
  end

  // Validate the latched configuration; slots beyond N are ignored.
  always_comb begin
    cfg_err = (qtd_q == 3'd0) || (int'(qtd_q) > MAX_CAMADAS) || (int'(qtd_q) > NUM_SLOTS);
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (k < int'(qtd_q)) begin
        cfg_err = cfg_err | desc_invalido(desc_q[k]);
      end
    end
  end

  montador_palavra u_montador (
    .tag     (tag_atual),
    .camada  (camada),
    .desc    (desc_q[camada]),
    .qtd     (qtd_q),
    .chk     (chk_q),
    .palavra (palavra)
  );

  // Control FSM with registered outputs; strobes and done are single-cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado_q  <= StIdle;
      qtd_q     <= '0;
      desc_q    <= '0;
      idx_q     <= '0;
      gap_q     <= '0;
      chk_q     <= '0;
      instrucao <= '0;
      flag_inst <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      erro      <= 1'b0;
    end else begin
      flag_inst <= 1'b0;
      done      <= 1'b0;
      case (estado_q)
        StIdle: begin
          if (start) begin
            qtd_q    <= cfg_qtd_camadas;
            desc_q   <= cfg_camadas;
            idx_q    <= '0;
            gap_q    <= '0;
            erro     <= 1'b0;
            busy     <= 1'b1;
            estado_q <= StCheck;
          end
        end
        StCheck: begin
          estado_q <= cfg_err ? StErr : StSend;
        end
        StSend: begin
          if (!hold) begin
            instrucao <= palavra;
            flag_inst <= 1'b1;
            idx_q     <= idx_q + 4'd1;
            gap_q     <= '0;
            chk_q     <= (tag_atual == TAG_HDR) ? palavra[7:0] : (chk_q ^ palavra[7:0]);
            if (tag_atual == TAG_END) begin
              estado_q <= StDone;
            end else if (GAP != 0) begin
              estado_q <= StGap;
            end
          end
        end
        StGap: begin
          // hold is not looked at here; it only gates the next SEND.
          if (gap_q == GAP_FIM) begin
            gap_q    <= '0;
            estado_q <= StSend;
          end else begin
            gap_q <= gap_q + 4'd1;
          end
        end
        StDone: begin
          done     <= 1'b1;
          busy     <= 1'b0;
          estado_q <= StIdle;
        end
        StErr: begin
          erro     <= 1'b1;
          busy     <= 1'b0;
          estado_q <= StIdle;
        end
        default: estado_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_emissor_instrucao.sv
// Scoreboard bench for emissor_instrucao: tests push hand-computed words into a
// queue and a negedge monitor pops and compares on every flag_inst strobe.
module tb_emissor_instrucao;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        hold = 1'b0;
  logic [2:0]  cfg_qtd_camadas = '0;
  logic [51:0] cfg_camadas = '0;
  logic [9:0]  instrucao;
  logic        flag_inst;
  logic        busy;
  logic        done;
  logic        erro;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          strobe_cnt = 0;
  int          t_start = 0;
  logic        hold_s = 1'b0;
  logic [9:0]  exp_q[$];
  int          strobe_cyc[$];

  emissor_instrucao #(
    .GAP         (2),
    .MAX_CAMADAS (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .hold            (hold),
    .cfg_qtd_camadas (cfg_qtd_camadas),
    .cfg_camadas     (cfg_camadas),
    .instrucao       (instrucao),
    .flag_inst       (flag_inst),
    .busy            (busy),
    .done            (done),
    .erro            (erro)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    hold_s <= hold;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor: every strobe is compared against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst && flag_inst) begin
      strobe_cnt++;
      strobe_cyc.push_back(cyc);
      chk("strobe_while_hold", 32'(hold_s), 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", 32'(instrucao), 32'h3ff_ffff);
      end else begin
        chk("word", 32'(instrucao), 32'(exp_q.pop_front()));
      end
    end
  end

  function automatic logic [51:0] cfg4(input logic [12:0] d0, input logic [12:0] d1,
                                       input logic [12:0] d2, input logic [12:0] d3);
    return {d3, d2, d1, d0};
  endfunction

  // One-cycle start pulse; config inputs are scrambled afterwards.
  task automatic do_start(input logic [2:0] n, input logic [51:0] cfg);
    @(negedge clk);
    cfg_qtd_camadas = n;
    cfg_camadas     = cfg;
    start           = 1'b1;
    t_start         = cyc + 1;
    @(negedge clk);
    start           = 1'b0;
    cfg_qtd_camadas = 3'($urandom);
    cfg_camadas     = {20'($urandom), $urandom};
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        chk({name, "_busy_at_done"}, 32'(busy), 32'd0);
        if (strobe_cyc.size() > 0) chk({name, "_done_lat"}, 32'(cyc), 32'(strobe_cyc[$] + 1));
        @(negedge clk);
        chk({name, "_done_pulse"}, 32'(done), 32'd0);
      end
    end
    if (!seen) chk({name, "_done_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_err(input string name, input logic [2:0] n, input logic [51:0] cfg);
    int s0 = strobe_cnt;
    int nb = 1;
    do_start(n, cfg);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy) nb++;
    end
    chk({name, "_busy_cycles"}, 32'(nb), 32'd2);
    chk({name, "_erro"}, 32'(erro), 32'd1);
    chk({name, "_strobes"}, 32'(strobe_cnt - s0), 32'd0);
  endtask

  task automatic push_t1;
    exp_q.push_back(10'h001);
    exp_q.push_back(10'h1A3);
    exp_q.push_back(10'h202);
    exp_q.push_back(10'h3A0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int cnt;
    repeat (3) @(negedge clk);
    chk("rst_outs", 32'({instrucao, flag_inst, busy, done, erro}), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_outs", 32'({instrucao, flag_inst, busy, done, erro}), 32'd0);

    // N=1, timing and spacing.
    s0 = strobe_cyc.size();
    push_t1();
    do_start(3'd1, cfg4(13'h02A3, 13'h0, 13'h0, 13'h0));
    chk("t1_busy", 32'(busy), 32'd1);
    wait_done("t1", 60);
    chk("t1_count", 32'(strobe_cyc.size() - s0), 32'd4);
    if (strobe_cyc.size() >= s0 + 4) begin
      chk("t1_first_lat", 32'(strobe_cyc[s0]), 32'(t_start + 2));
      for (int i = 1; i < 4; i++) begin
        chk("t1_spacing", 32'(strobe_cyc[s0 + i] - strobe_cyc[s0 + i - 1]), 32'd3);
      end
    end

    // N=4, start pulsed again mid-frame with scrambled config.
    s0 = strobe_cnt;
    exp_q.push_back(10'h004);
    exp_q.push_back(10'h101);
    exp_q.push_back(10'h213);
    exp_q.push_back(10'h1E4);
    exp_q.push_back(10'h245);
    exp_q.push_back(10'h172);
    exp_q.push_back(10'h28A);
    exp_q.push_back(10'h1B3);
    exp_q.push_back(10'h2C0);
    exp_q.push_back(10'h33C);
    do_start(3'd4, cfg4(13'h1301, 13'h05E4, 13'h0A72, 13'h00B3));
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t2", 120);
    chk("t2_count", 32'(strobe_cnt - s0), 32'd10);

    // Configuration errors.
    run_err("n0", 3'd0, cfg4(13'h02A3, 13'h0, 13'h0, 13'h0));
    run_err("n5", 3'd5, cfg4(13'h02A3, 13'h02A3, 13'h02A3, 13'h02A3));
    run_err("neuro20", 3'd2, cfg4(13'h02A3, 13'h1405, 13'h0, 13'h0));
    run_err("entr20", 3'd1, cfg4(13'h0014, 13'h0, 13'h0, 13'h0));

    // Bad descriptor in an unused slot is accepted; erro clears on start.
    exp_q.push_back(10'h002);
    exp_q.push_back(10'h1A3);
    exp_q.push_back(10'h202);
    exp_q.push_back(10'h105);
    exp_q.push_back(10'h241);
    exp_q.push_back(10'h3E7);
    do_start(3'd2, cfg4(13'h02A3, 13'h0105, 13'h0, 13'h1400));
    chk("erro_cleared", 32'(erro), 32'd0);
    wait_done("t_unused", 80);
    chk("t_unused_erro", 32'(erro), 32'd0);

    // hold for 7 cycles right after the first strobe.
    push_t1();
    do_start(3'd1, cfg4(13'h02A3, 13'h0, 13'h0, 13'h0));
    cnt = 0;
    for (int i = 0; i < 20 && cnt == 0; i++) begin
      @(negedge clk);
      if (flag_inst) cnt = 1;
    end
    hold = 1'b1;
    repeat (7) @(negedge clk);
    hold = 1'b0;
    wait_done("t_hold", 80);

    // Reset after the third word, then a fresh frame from HEADER.
    push_t1();
    do_start(3'd1, cfg4(13'h02A3, 13'h0, 13'h0, 13'h0));
    cnt = 0;
    for (int i = 0; i < 40 && cnt < 3; i++) begin
      @(negedge clk);
      if (flag_inst) cnt++;
    end
    chk("rst_pre_words", 32'(cnt), 32'd3);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("rst_mid_outs", 32'({instrucao, flag_inst, busy, done, erro}), 32'd0);
    rst = 1'b1;
    s0 = strobe_cnt;
    repeat (8) @(negedge clk);
    chk("rst_no_strobe", 32'(strobe_cnt - s0), 32'd0);
    chk("rst_idle_busy", 32'(busy), 32'd0);
    push_t1();
    do_start(3'd1, cfg4(13'h02A3, 13'h0, 13'h0, 13'h0));
    wait_done("t_restart", 60);

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
